// File: rtl/lc3_execute.sv
// LC-3 execute stage: ALU, address adder, condition codes and the pipeline
// register feeding the memory-access and writeback stages.
module lc3_execute #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_execute,
  input  logic [5:0]    E_control,
  input  logic          Mem_control_in,
  input  logic [1:0]    W_control_in,
  input  logic [DW-1:0] IR,
  input  logic [DW-1:0] npc_in,
  input  logic [DW-1:0] VSR1,
  input  logic [DW-1:0] VSR2,
  input  logic          bypass_alu_1,
  input  logic          bypass_alu_2,
  input  logic          bypass_mem_1,
  input  logic          bypass_mem_2,
  input  logic [DW-1:0] Mem_Bypass_Val,
  output logic [2:0]    sr1,
  output logic [2:0]    sr2,
  output logic [DW-1:0] aluout,
  output logic [DW-1:0] pcout,
  output logic [DW-1:0] M_Data,
  output logic [2:0]    dr,
  output logic [DW-1:0] IR_Exec,
  output logic [2:0]    NZP,
  output logic [1:0]    W_control_out,
  output logic          Mem_control_out
);

  logic [1:0]    alu_control;
  logic [1:0]    pcselect1;
  logic          pcselect2;
  logic          op2select;
  logic [3:0]    opcode;
  logic [DW-1:0] op1, op2, op2_alu;
  logic [DW-1:0] base, offset, addr;
  logic [DW-1:0] alu_res, result;
  logic [2:0]    nzp_next, dr_next;
  logic          alu_op, sets_cc, no_dest;

  assign alu_control = E_control[5:4];
  assign pcselect1   = E_control[3:2];
  assign pcselect2   = E_control[1];
  assign op2select   = E_control[0];
  assign opcode      = IR[15:12];

  assign sr1 = IR[8:6];
  assign sr2 = IR[2:0];

  // ALU forwarding takes priority over memory forwarding
  assign op1 = bypass_alu_1 ? aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
  assign op2 = bypass_alu_2 ? aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
  assign op2_alu = op2select ? op2 : {{11{IR[4]}}, IR[4:0]};

  always_comb begin
    offset = '0;
    case (pcselect1)
      2'b00:   offset = {{5{IR[10]}}, IR[10:0]};
      2'b01:   offset = {{7{IR[8]}}, IR[8:0]};
      2'b10:   offset = {{10{IR[5]}}, IR[5:0]};
      default: offset = '0;
    endcase
  end

  assign base = pcselect2 ? npc_in : op1;
  assign addr = base + offset;

  always_comb begin
    alu_res = '0;
    case (alu_control)
      2'b00:   alu_res = op1 + op2_alu;
      2'b01:   alu_res = op1 & op2_alu;
      2'b10:   alu_res = ~op1;
      default: alu_res = op1;
    endcase
  end

  assign alu_op  = (opcode == 4'b0001) || (opcode == 4'b0101) || (opcode == 4'b1001);
  assign sets_cc = alu_op || (opcode == 4'b1110);
  assign no_dest = (opcode == 4'b0000) || (opcode == 4'b0011) || (opcode == 4'b0111) ||
                   (opcode == 4'b1011) || (opcode == 4'b1100);

  assign result  = alu_op ? alu_res : addr;
  assign dr_next = no_dest ? 3'b000 : IR[11:9];

  always_comb begin
    nzp_next = 3'b000;
    if (sets_cc) begin
      if (result[DW-1])       nzp_next = 3'b100;
      else if (result == '0)  nzp_next = 3'b010;
      else                    nzp_next = 3'b001;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aluout          <= '0;
      pcout           <= '0;
      M_Data          <= '0;
      dr              <= '0;
      IR_Exec         <= '0;
      NZP             <= '0;
      W_control_out   <= '0;
      Mem_control_out <= 1'b0;
    end else if (enable_execute) begin
      aluout          <= result;
      pcout           <= addr;
      M_Data          <= op2;
      dr              <= dr_next;
      IR_Exec         <= IR;
      NZP             <= nzp_next;
      W_control_out   <= W_control_in;
      Mem_control_out <= Mem_control_in;
    end
  end

endmodule
